// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 receive path: the frame FSM state type,
// the two scan-code prefix bytes, the default filter and watchdog sizes,
// and a helper that decides whether a completed frame is well formed.
// ---------------------------------------------------------------------------
package ps2_pkg;

   // Frame receiver states. IDLE waits for a start bit (data low on a
   // falling clock edge); DATA collects eight bits LSB first; PARITY and
   // STOP each take a single sample.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   // Prefix bytes: E0 marks an extended key, F0 marks a key release.
   localparam logic [7:0] PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PREFIX_REL = 8'hF0;

   // Default glitch-filter depth and idle-bit watchdog limit
   // (100000 cycles is 2 ms at 50 MHz).
   localparam int FILT_DEFAULT = 8;
   localparam int TMO_DEFAULT  = 100000;

   // A frame is good when the stop bit is high and the eight data bits
   // plus the parity bit hold an odd number of ones.
   function automatic logic frame_good(input logic [7:0] data,
                                       input logic       par,
                                       input logic       stop);
      return stop & (^{data, par});
   endfunction

endpackage

// File: rtl/ps2_rx_frame_if.sv
// ---------------------------------------------------------------------------
// ps2_rx_frame_if
// Bundles the PS/2 line pair and the decoded scan-code outputs.
//   ps2_clk, ps2_dat : raw PS/2 lines, driven by the device side (master)
//   code             : last completed non-prefix scan code
//   ext              : code was preceded by E0
//   rel              : code was preceded by F0 (key release)
//   valid            : one-cycle strobe, code/ext/rel are new
//   err              : one-cycle strobe, framing, parity or timeout error
// The master modport is the keyboard/host-bench side, the slave modport is
// the receiver.
// ---------------------------------------------------------------------------
interface ps2_rx_frame_if;

   logic       ps2_clk;
   logic       ps2_dat;
   logic [7:0] code;
   logic       ext;
   logic       rel;
   logic       valid;
   logic       err;

   modport master (
      output ps2_clk,
      output ps2_dat,
      input  code,
      input  ext,
      input  rel,
      input  valid,
      input  err
   );

   modport slave (
      input  ps2_clk,
      input  ps2_dat,
      output code,
      output ext,
      output rel,
      output valid,
      output err
   );

endinterface

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Brings one raw, asynchronous PS/2 line into the clk domain and removes
// short glitches.
//   clk   : system clock
//   reset : synchronous, active-high reset; everything returns to the idle
//           (high) line level
//   raw   : asynchronous PS/2 line
//   level : filtered line level
// The filtered level only follows the synchronized input once the two have
// disagreed for FILT consecutive cycles; any agreement restarts the count.
// ---------------------------------------------------------------------------
module ps2_line_filter #(
   parameter int FILT = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level
);

   localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);

   logic          sync_a;
   logic          sync_b;
   logic [CW-1:0] cnt;

   // Two-flop synchronizer followed by the stability counter. The counter
   // holds the number of cycles the synchronized line has already differed
   // from the filtered level; on the FILT-th differing cycle the level flips.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a <= 1'b1;
         sync_b <= 1'b1;
         level  <= 1'b1;
         cnt    <= '0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
         if (sync_b == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync_b;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_rx_frame.sv
// ---------------------------------------------------------------------------
// ps2_rx_frame
// PS/2 device-to-host frame receiver with scan-code prefix tracking.
//   clk   : system clock, single domain, rising edge
//   reset : synchronous, active-high reset
//   bus   : ps2_rx_frame_if.slave
//           ps2_clk/ps2_dat in  - raw PS/2 lines
//           code        out - last completed non-prefix scan code
//           ext         out - code was preceded by E0
//           rel         out - code was preceded by F0
//           valid       out - one-cycle strobe, code/ext/rel updated
//           err         out - one-cycle strobe, framing/parity/timeout
// Parameters:
//   FILT : stable cycles needed before a filtered line changes level
//   TMO  : watchdog limit in clk cycles between samples inside a frame
// Both lines are filtered, and the falling edge of the filtered clock is
// the only point at which the data line is sampled.
// ---------------------------------------------------------------------------
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int FILT = FILT_DEFAULT,
   parameter int TMO  = TMO_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   ps2_rx_frame_if.slave   bus
);

   localparam int WW = $clog2(TMO + 1);
   localparam logic [WW-1:0] WDOG_LAST = WW'(TMO - 1);

   logic clk_f;
   logic dat_f;
   logic clk_f_d;
   logic sample;

   state_t        state,    state_n;
   logic [2:0]    bitcnt,   bitcnt_n;
   logic [7:0]    shift,    shift_n;
   logic          par_bit,  par_bit_n;
   logic [WW-1:0] wdog,     wdog_n;
   logic          ext_pend, ext_pend_n;
   logic          rel_pend, rel_pend_n;
   logic [7:0]    code_q,   code_n;
   logic          ext_q,    ext_n;
   logic          rel_q,    rel_n;
   logic          valid_q,  valid_n;
   logic          err_q,    err_n;

   // One filter per raw line.
   ps2_line_filter #(.FILT(FILT)) u_clk_filter (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.ps2_clk),
      .level (clk_f)
   );

   ps2_line_filter #(.FILT(FILT)) u_dat_filter (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.ps2_dat),
      .level (dat_f)
   );

   // Delayed copy of the filtered clock for falling-edge detection. It
   // resets high so that a line that is already idle never looks like an
   // edge when reset is released.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_f_d <= 1'b1;
      end else begin
         clk_f_d <= clk_f;
      end
   end

   assign sample = clk_f_d & ~clk_f;

   // State register for the frame FSM, the datapath it owns and the
   // registered output strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         bitcnt   <= '0;
         shift    <= '0;
         par_bit  <= 1'b0;
         wdog     <= '0;
         ext_pend <= 1'b0;
         rel_pend <= 1'b0;
         code_q   <= 8'h00;
         ext_q    <= 1'b0;
         rel_q    <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_n;
         bitcnt   <= bitcnt_n;
         shift    <= shift_n;
         par_bit  <= par_bit_n;
         wdog     <= wdog_n;
         ext_pend <= ext_pend_n;
         rel_pend <= rel_pend_n;
         code_q   <= code_n;
         ext_q    <= ext_n;
         rel_q    <= rel_n;
         valid_q  <= valid_n;
         err_q    <= err_n;
      end
   end

   // Next-state and datapath logic. Strobes are computed in the cycle the
   // stop bit is sampled and registered, so they appear one cycle later and
   // last exactly one cycle. The watchdog only runs while a frame is in
   // progress; a sample in the same cycle as an expiry takes priority, so
   // a slow but still live frame is never aborted.
   always_comb begin
      state_n    = state;
      bitcnt_n   = bitcnt;
      shift_n    = shift;
      par_bit_n  = par_bit;
      wdog_n     = wdog;
      ext_pend_n = ext_pend;
      rel_pend_n = rel_pend;
      code_n     = code_q;
      ext_n      = ext_q;
      rel_n      = rel_q;
      valid_n    = 1'b0;
      err_n      = 1'b0;

      if (state == IDLE || sample) begin
         wdog_n = '0;
      end else begin
         wdog_n = wdog + WW'(1);
      end

      case (state)
         IDLE: begin
            if (sample && !dat_f) begin
               state_n  = DATA;
               bitcnt_n = '0;
            end
         end

         DATA: begin
            if (sample) begin
               shift_n  = {dat_f, shift[7:1]};
               bitcnt_n = bitcnt + 3'd1;
               if (bitcnt == 3'd7) begin
                  state_n = PARITY;
               end
            end
         end

         PARITY: begin
            if (sample) begin
               par_bit_n = dat_f;
               state_n   = STOP;
            end
         end

         STOP: begin
            if (sample) begin
               state_n = IDLE;
               if (frame_good(shift, par_bit, dat_f)) begin
                  if (shift == PREFIX_EXT) begin
                     ext_pend_n = 1'b1;
                  end else if (shift == PREFIX_REL) begin
                     rel_pend_n = 1'b1;
                  end else begin
                     code_n     = shift;
                     ext_n      = ext_pend;
                     rel_n      = rel_pend;
                     valid_n    = 1'b1;
                     ext_pend_n = 1'b0;
                     rel_pend_n = 1'b0;
                  end
               end else begin
                  err_n      = 1'b1;
                  ext_pend_n = 1'b0;
                  rel_pend_n = 1'b0;
               end
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase

      // Watchdog expiry abandons the frame and any pending prefix.
      if (state != IDLE && !sample && wdog == WDOG_LAST) begin
         state_n    = IDLE;
         wdog_n     = '0;
         err_n      = 1'b1;
         ext_pend_n = 1'b0;
         rel_pend_n = 1'b0;
      end
   end

   assign bus.code  = code_q;
   assign bus.ext   = ext_q;
   assign bus.rel   = rel_q;
   assign bus.valid = valid_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx_frame
// Self-checking bench for ps2_rx_frame. Frames are driven as a PS/2 device
// would (data changes while the clock is high, the host samples on the
// falling edge). Each driven frame pushes its expected outcome onto a
// scoreboard; a monitor pops and compares whenever valid or err fires.
// ---------------------------------------------------------------------------
module tb_ps2_rx_frame;
   import ps2_pkg::*;

   localparam int FILT      = 8;
   localparam int TMO       = 2000;
   localparam int HALF      = 40;
   localparam int HALF_SLOW = 750;
   localparam int TMO_DELAY = 3 + FILT + TMO;

   typedef struct {
      bit         is_err;
      logic [7:0] code;
      bit         ext;
      bit         rel;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   int   checks = 0;
   int   fails  = 0;
   exp_t sb[$];
   exp_t mon_e;
   bit   m_ext = 1'b0;
   bit   m_rel = 1'b0;

   ps2_rx_frame_if bus ();

   ps2_rx_frame #(.FILT(FILT), .TMO(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // 50 MHz system clock.
   always #10 clk = ~clk;

   // Scoreboard monitor: every strobe must match the oldest expectation.
   always @(negedge clk) begin
      if (reset === 1'b0 && (bus.valid === 1'b1 || bus.err === 1'b1)) begin
         checks++;
         if (bus.valid === 1'b1 && bus.err === 1'b1) begin
            fails++;
            $display("[TB] FAIL strobe_overlap: valid=%b err=%b, required not both", bus.valid, bus.err);
         end
         checks++;
         if (sb.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_strobe: valid=%b err=%b code=%h, required no strobe", bus.valid, bus.err, bus.code);
         end else begin
            mon_e = sb.pop_front();
            if (bus.err !== mon_e.is_err) begin
               fails++;
               $display("[TB] FAIL strobe_kind: err=%b valid=%b, required err=%b", bus.err, bus.valid, mon_e.is_err);
            end else if (!mon_e.is_err && {bus.code, bus.ext, bus.rel} !== {mon_e.code, mon_e.ext, mon_e.rel}) begin
               fails++;
               $display("[TB] FAIL decoded_code: code=%h ext=%b rel=%b, required code=%h ext=%b rel=%b",
                        bus.code, bus.ext, bus.rel, mon_e.code, mon_e.ext, mon_e.rel);
            end
         end
      end
   end

   // Reference behaviour for one completed frame.
   task automatic model_frame(input logic [7:0] data, input bit bad);
      if (bad) begin
         sb.push_back('{1'b1, 8'h00, 1'b0, 1'b0});
         m_ext = 1'b0;
         m_rel = 1'b0;
      end else if (data == PREFIX_EXT) begin
         m_ext = 1'b1;
      end else if (data == PREFIX_REL) begin
         m_rel = 1'b1;
      end else begin
         sb.push_back('{1'b0, data, m_ext, m_rel});
         m_ext = 1'b0;
         m_rel = 1'b0;
      end
   endtask

   task automatic model_timeout();
      sb.push_back('{1'b1, 8'h00, 1'b0, 1'b0});
      m_ext = 1'b0;
      m_rel = 1'b0;
   endtask

   task automatic drive_bit(input logic b, input int half);
      bus.ps2_dat = b;
      repeat (half) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (half) @(negedge clk);
      bus.ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] data, input int half, input bit bad);
      logic par;
      par = bad ? (^data) : ~(^data);
      model_frame(data, bad);
      drive_bit(1'b0, half);
      for (int i = 0; i < 8; i++) drive_bit(data[i], half);
      drive_bit(par, half);
      drive_bit(1'b1, half);
      repeat (half) @(negedge clk);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         fails++;
         $display("[TB] FAIL %s_drain: %0d expected strobes outstanding, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   // Pulls ps2_clk low now, releases it after low_len cycles and requires
   // the watchdog err exactly TMO cycles after the resulting sample.
   task automatic expect_timeout(input string name, input int low_len);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      model_timeout();
      bus.ps2_clk = 1'b0;
      while (!seen && n < TMO_DELAY + 100) begin
         @(negedge clk);
         n++;
         if (n == low_len) bus.ps2_clk = 1'b1;
         if (bus.err === 1'b1) seen = 1'b1;
      end
      bus.ps2_clk = 1'b1;
      checks++;
      if (!seen || n != TMO_DELAY) begin
         fails++;
         $display("[TB] FAIL %s_timing: err after %0d cycles (seen=%b), required %0d", name, n, seen, TMO_DELAY);
      end
      wait_drain(name);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      bus.ps2_clk = 1'b1;
      bus.ps2_dat = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      m_ext = 1'b0;
      m_rel = 1'b0;
      sb.delete();
      repeat (FILT + 4) @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (bus.code !== 8'h00) begin
         fails++;
         $display("[TB] FAIL reset_code: code=%h, required 00", bus.code);
      end
      checks++;
      if ({bus.ext, bus.rel, bus.valid, bus.err} !== 4'b0000) begin
         fails++;
         $display("[TB] FAIL reset_flags: ext/rel/valid/err=%b, required 0000", {bus.ext, bus.rel, bus.valid, bus.err});
      end
   endtask

   task automatic test_single_frame();
      send_frame(8'h1C, HALF_SLOW, 1'b0);
      wait_drain("single");
      repeat (50) @(negedge clk);
      checks++;
      if ({bus.code, bus.ext, bus.rel} !== {8'h1C, 1'b0, 1'b0}) begin
         fails++;
         $display("[TB] FAIL single_hold: code=%h ext=%b rel=%b, required 1c 0 0", bus.code, bus.ext, bus.rel);
      end
   endtask

   task automatic test_prefixes();
      send_frame(PREFIX_EXT, HALF, 1'b0);
      send_frame(PREFIX_REL, HALF, 1'b0);
      send_frame(8'h75, HALF, 1'b0);
      wait_drain("ext_rel");
      send_frame(PREFIX_EXT, HALF, 1'b0);
      send_frame(8'h6B, HALF, 1'b0);
      wait_drain("ext_only");
      send_frame(PREFIX_REL, HALF, 1'b0);
      send_frame(8'h1C, HALF, 1'b0);
      wait_drain("rel_only");
   endtask

   task automatic test_parity_error();
      send_frame(8'h1C, HALF, 1'b1);
      send_frame(8'h1C, HALF, 1'b0);
      wait_drain("parity");
      send_frame(PREFIX_EXT, HALF, 1'b0);
      send_frame(8'h33, HALF, 1'b1);
      send_frame(8'h75, HALF, 1'b0);
      wait_drain("err_clears_pend");
   endtask

   task automatic test_glitch();
      // With data low, any sampled clock edge would start a frame.
      bus.ps2_dat = 1'b0;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      expect_timeout("long_pulse", 20);
      bus.ps2_dat = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic test_timeout();
      drive_bit(1'b0, HALF);
      drive_bit(1'b1, HALF);
      drive_bit(1'b0, HALF);
      drive_bit(1'b1, HALF);
      bus.ps2_dat = 1'b1;
      repeat (HALF) @(negedge clk);
      expect_timeout("stall", HALF);
      repeat (HALF) @(negedge clk);
      send_frame(8'h29, HALF, 1'b0);
      wait_drain("after_stall");
   endtask

   task automatic test_reset_mid_frame();
      send_frame(PREFIX_REL, HALF, 1'b0);
      drive_bit(1'b0, HALF);
      drive_bit(1'b1, HALF);
      drive_bit(1'b1, HALF);
      apply_reset();
      checks++;
      if (bus.code !== 8'h00) begin
         fails++;
         $display("[TB] FAIL midreset_code: code=%h, required 00", bus.code);
      end
      send_frame(8'h5A, HALF, 1'b0);
      wait_drain("midreset");
   endtask

   task automatic test_back_to_back();
      logic [7:0] tbl [6];
      tbl = '{8'h16, 8'h1E, 8'h26, PREFIX_EXT, PREFIX_REL, 8'h4A};
      for (int i = 0; i < 6; i++) send_frame(tbl[i], HALF, 1'b0);
      wait_drain("back_to_back");
   endtask

   initial begin
      bus.ps2_clk = 1'b1;
      bus.ps2_dat = 1'b1;
      test_reset();
      test_single_frame();
      test_prefixes();
      test_parity_error();
      test_glitch();
      test_timeout();
      test_reset_mid_frame();
      test_back_to_back();
      repeat (100) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
